// File: rtl/exa_crosb_pkg.sv
// exa_crosb_pkg: shared types and helpers for the packet-locked crossbar output mux.
package exa_crosb_pkg;
  typedef enum logic {IDLE, LOCKED} mux_state_t;
  function automatic int clog2_min1(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/exa_skid_buf2.sv
// exa_skid_buf2: 2-entry skid buffer; head entry is always held in e0_q.
module exa_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] e0_q, e1_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      if (pop_i) e0_q <= (cnt_q == 2'd2) ? e1_q : din_i;
      else if (push_i && cnt_q == 2'd0) e0_q <= din_i;
      if (push_i && ((cnt_q == 2'd1 && !pop_i) || (cnt_q == 2'd2 && pop_i))) e1_q <= din_i;
    end
  assign dout_o = e0_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/exa_crosb_pkt_mux.sv
// exa_crosb_pkt_mux: packet-locked crossbar output mux with skid-buffered, back-pressured output.
module exa_crosb_pkt_mux import exa_crosb_pkg::*; #(
  parameter int DATA_WIDTH    = 128,
  parameter int INPUT_NUM     = 16,
  parameter int SEL_WIDTH     = clog2_min1(INPUT_NUM),
  parameter int MAX_PKT_BEATS = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] DATA_i [INPUT_NUM],
  input  logic [INPUT_NUM-1:0]  VALID_i,
  input  logic [INPUT_NUM-1:0]  LAST_i,
  input  logic [INPUT_NUM-1:0]  PRIO_i,
  output logic [INPUT_NUM-1:0]  READY_o,
  input  logic [SEL_WIDTH-1:0]  SEL_i,
  input  logic                  SEL_VALID_i,
  output logic                  SEL_ACK_o,
  output logic [DATA_WIDTH-1:0] DATA_o,
  output logic                  VALID_o,
  output logic                  LAST_o,
  output logic                  PRIO_o,
  input  logic                  READY_i,
  output logic                  BUSY_o,
  output logic                  PKT_DONE_o,
  output logic                  ERR_o
);
  localparam int CW = clog2_min1(MAX_PKT_BEATS);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  prio;
  } beat_t;
  mux_state_t           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [CW-1:0]        beat_cnt_q;
  logic                 err_q, done_q, ack, rdy, acc, wd, pop;
  logic [1:0]           cnt;
  beat_t                in_beat, head;
  logic [DATA_WIDTH+1:0] head_raw;
  assign ack = state_q == IDLE && SEL_VALID_i && {1'b0, SEL_i} < (SEL_WIDTH+1)'(INPUT_NUM);
  // READY is decoded from state and fill level only, so no path from READY_i
  assign rdy = state_q == LOCKED && cnt < 2'd2;
  assign acc = VALID_i[sel_q] && rdy;
  assign wd  = acc && !LAST_i[sel_q] && beat_cnt_q == CW'(MAX_PKT_BEATS - 1);
  assign in_beat = '{data: DATA_i[sel_q], last: LAST_i[sel_q] || wd, prio: PRIO_i[sel_q]};
  assign pop  = cnt != 2'd0 && READY_i;
  assign head = beat_t'(head_raw);
  exa_skid_buf2 #(.W(DATA_WIDTH + 2)) u_skid (
    .clk    (clk),
    .rst_n  (resetn),
    .push_i (acc),
    .din_i  (in_beat),
    .pop_i  (pop),
    .dout_o (head_raw),
    .cnt_o  (cnt)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? (ack ? LOCKED : IDLE) : ((acc && in_beat.last) ? IDLE : LOCKED);
  always_comb begin
    SEL_ACK_o  = ack;
    READY_o    = rdy ? (INPUT_NUM'(1) << sel_q) : '0;
    VALID_o    = cnt != 2'd0;
    BUSY_o     = state_q == LOCKED || cnt != 2'd0;
    DATA_o     = head.data;
    LAST_o     = head.last;
    PRIO_o     = head.prio;
    PKT_DONE_o = done_q;
    ERR_o      = err_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sel_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (ack) sel_q <= SEL_i;
      if (ack) beat_cnt_q <= '0;
      else if (acc && !(&beat_cnt_q)) beat_cnt_q <= beat_cnt_q + 1'b1;
      err_q  <= wd;
      done_q <= pop && head.last;
    end
endmodule

// File: tb/tb_exa_crosb_pkt_mux.sv
// tb_exa_crosb_pkt_mux: directed checks of grant locking, skid buffering, watchdog and reset.
module tb_exa_crosb_pkt_mux;
  localparam int DW = 16;
  localparam int N  = 12;
  localparam int MB = 8;
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] DATA_i [N];
  logic [N-1:0]  VALID_i, LAST_i, PRIO_i, READY_o;
  logic [3:0]    SEL_i;
  logic          SEL_VALID_i, SEL_ACK_o, VALID_o, LAST_o, PRIO_o, READY_i, BUSY_o, PKT_DONE_o, ERR_o;
  logic [DW-1:0] DATA_o;
  int            passes = 0, total = 0, done_n = 0, r7_n = 0;
  logic [17:0]   got [$];
  always #5 clk = ~clk;
  exa_crosb_pkt_mux #(.DATA_WIDTH(DW), .INPUT_NUM(N), .MAX_PKT_BEATS(MB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .DATA_i     (DATA_i),
    .VALID_i    (VALID_i),
    .LAST_i     (LAST_i),
    .PRIO_i     (PRIO_i),
    .READY_o    (READY_o),
    .SEL_i      (SEL_i),
    .SEL_VALID_i(SEL_VALID_i),
    .SEL_ACK_o  (SEL_ACK_o),
    .DATA_o     (DATA_o),
    .VALID_o    (VALID_o),
    .LAST_o     (LAST_o),
    .PRIO_o     (PRIO_o),
    .READY_i    (READY_i),
    .BUSY_o     (BUSY_o),
    .PKT_DONE_o (PKT_DONE_o),
    .ERR_o      (ERR_o)
  );
  // Output-side observer: records every beat that will be handshaken on the next edge
  always @(negedge clk)
    if (resetn) begin
      if (VALID_o && READY_i) got.push_back({LAST_o, PRIO_o, DATA_o});
      if (PKT_DONE_o) done_n++;
      if (READY_o[7]) r7_n++;
    end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  function automatic logic [18:0] outv();
    return {VALID_o, LAST_o, PRIO_o, DATA_o};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic grant(logic [3:0] s, logic exp_ack);
    SEL_i = s;
    SEL_VALID_i = 1'b1;
    #1;
    chk("sel_ack", 32'(SEL_ACK_o), 32'(exp_ack));
    cyc();
    SEL_VALID_i = 1'b0;
  endtask
  task automatic push_beat(int ch, logic [15:0] d, logic l, logic p);
    int n = 0;
    VALID_i[ch] = 1'b1;
    DATA_i[ch]  = d;
    LAST_i[ch]  = l;
    PRIO_i[ch]  = p;
    while (!READY_o[ch] && n < 20) begin
      cyc();
      n++;
    end
    chk("accept", 32'(n < 20), 32'd1);
    cyc();
    VALID_i[ch] = 1'b0;
    LAST_i[ch]  = 1'b0;
    PRIO_i[ch]  = 1'b0;
  endtask
  task automatic chk_seq(string tag, int base, input logic [17:0] e [$]);
    chk({tag, "_len"}, 32'(got.size() - base), 32'(e.size()));
    foreach (e[i]) if (base + i < got.size()) chk(tag, 32'(got[base + i]), 32'(e[i]));
  endtask
  initial begin
    logic [17:0] e [$];
    int base, d0;
    VALID_i = '0;
    LAST_i = '0;
    PRIO_i = '0;
    for (int i = 0; i < N; i++) DATA_i[i] = '0;
    SEL_i = '0;
    SEL_VALID_i = 1'b0;
    READY_i = 1'b0;
    repeat (2) cyc();
    chk("rst_out", 32'(outv()), 32'h0);
    chk("rst_busy", 32'(BUSY_o), 32'h0);
    chk("rst_ready", 32'(READY_o), 32'h0);
    chk("rst_flags", 32'({PKT_DONE_o, ERR_o, SEL_ACK_o}), 32'h0);
    resetn = 1'b1;
    READY_i = 1'b1;
    cyc();
    // 1: four-beat packet on input 3, full throughput
    grant(4'd3, 1'b1);
    chk("t1_ready", 32'(READY_o), 32'h008);
    chk("t1_busy", 32'(BUSY_o), 32'h1);
    chk("t1_empty", 32'(VALID_o), 32'h0);
    VALID_i[3] = 1'b1;
    DATA_i[3] = 16'h3001;
    cyc();
    chk("t1_b1", 32'(outv()), 32'h43001);
    DATA_i[3] = 16'h3002;
    cyc();
    chk("t1_b2", 32'(outv()), 32'h43002);
    DATA_i[3] = 16'h3003;
    cyc();
    chk("t1_b3", 32'(outv()), 32'h43003);
    DATA_i[3] = 16'h3004;
    LAST_i[3] = 1'b1;
    PRIO_i[3] = 1'b1;
    cyc();
    chk("t1_b4", 32'(outv()), 32'h73004);
    chk("t1_ready_off", 32'(READY_o), 32'h0);
    chk("t1_done_early", 32'(PKT_DONE_o), 32'h0);
    VALID_i[3] = 1'b0;
    LAST_i[3] = 1'b0;
    PRIO_i[3] = 1'b0;
    cyc();
    chk("t1_done", 32'(PKT_DONE_o), 32'h1);
    chk("t1_drained", 32'({VALID_o, BUSY_o}), 32'h0);
    cyc();
    chk("t1_done_pulse", 32'(PKT_DONE_o), 32'h0);
    // 2: READY_i low three cycles mid-packet
    base = got.size();
    grant(4'd3, 1'b1);
    push_beat(3, 16'h3011, 1'b0, 1'b0);
    READY_i = 1'b0;
    push_beat(3, 16'h3012, 1'b0, 1'b0);
    chk("t2_ready_full", 32'(READY_o), 32'h0);
    chk("t2_head", 32'(outv()), 32'h43011);
    cyc();
    cyc();
    chk("t2_ready_stall", 32'(READY_o), 32'h0);
    READY_i = 1'b1;
    push_beat(3, 16'h3013, 1'b0, 1'b0);
    push_beat(3, 16'h3014, 1'b1, 1'b0);
    repeat (3) cyc();
    e = '{18'h03011, 18'h03012, 18'h03013, 18'h23014};
    chk_seq("t2_seq", base, e);
    // 3: next grant taken while input 3 drains; input 7 must never see READY
    base = got.size();
    d0 = done_n;
    VALID_i[7] = 1'b1;
    DATA_i[7] = 16'h7777;
    grant(4'd3, 1'b1);
    READY_i = 1'b0;
    push_beat(3, 16'h3021, 1'b0, 1'b0);
    push_beat(3, 16'h3022, 1'b1, 1'b0);
    chk("t3_busy_idle", 32'(BUSY_o), 32'h1);
    grant(4'd5, 1'b1);
    chk("t3_ready_full", 32'(READY_o), 32'h0);
    READY_i = 1'b1;
    push_beat(5, 16'h5001, 1'b0, 1'b0);
    push_beat(5, 16'h5002, 1'b0, 1'b0);
    push_beat(5, 16'h5003, 1'b1, 1'b0);
    repeat (4) cyc();
    e = '{18'h03021, 18'h23022, 18'h05001, 18'h05002, 18'h25003};
    chk_seq("t3_seq", base, e);
    chk("t3_done_cnt", 32'(done_n - d0), 32'd2);
    chk("t3_ready7", 32'(r7_n), 32'd0);
    VALID_i[7] = 1'b0;
    // 4: out-of-range selection is ignored
    grant(4'd14, 1'b0);
    chk("t4_busy", 32'(BUSY_o), 32'h0);
    chk("t4_ready", 32'(READY_o), 32'h0);
    cyc();
    chk("t4_busy_hold", 32'(BUSY_o), 32'h0);
    // 5: watchdog forces release on the 8th beat without LAST
    base = got.size();
    d0 = done_n;
    grant(4'd2, 1'b1);
    for (int i = 1; i <= MB; i++) push_beat(2, 16'(16'h2000 + i), 1'b0, 1'b0);
    chk("t5_err", 32'(ERR_o), 32'h1);
    chk("t5_ready", 32'(READY_o), 32'h0);
    chk("t5_head", 32'(outv()), 32'h62008);
    VALID_i[2] = 1'b1;
    DATA_i[2] = 16'h2009;
    cyc();
    chk("t5_err_pulse", 32'(ERR_o), 32'h0);
    chk("t5_done", 32'(PKT_DONE_o), 32'h1);
    chk("t5_idle", 32'({BUSY_o, READY_o}), 32'h0);
    DATA_i[2] = 16'h200a;
    cyc();
    VALID_i[2] = 1'b0;
    e = {};
    for (int i = 1; i < MB; i++) e.push_back(18'(18'h02000 + i));
    e.push_back(18'h22008);
    chk_seq("t5_seq", base, e);
    // 6: asynchronous reset with a full buffer, then a fresh packet
    grant(4'd4, 1'b1);
    READY_i = 1'b0;
    push_beat(4, 16'h4001, 1'b0, 1'b0);
    push_beat(4, 16'h4002, 1'b0, 1'b0);
    VALID_i[4] = 1'b1;
    DATA_i[4] = 16'h4003;
    resetn = 1'b0;
    #1;
    chk("t6_out", 32'(outv()), 32'h0);
    chk("t6_busy", 32'(BUSY_o), 32'h0);
    chk("t6_ready", 32'(READY_o), 32'h0);
    chk("t6_flags", 32'({PKT_DONE_o, ERR_o}), 32'h0);
    cyc();
    VALID_i[4] = 1'b0;
    cyc();
    resetn = 1'b1;
    READY_i = 1'b1;
    base = got.size();
    d0 = done_n;
    grant(4'd6, 1'b1);
    push_beat(6, 16'h6001, 1'b0, 1'b0);
    push_beat(6, 16'h6002, 1'b1, 1'b1);
    repeat (3) cyc();
    e = '{18'h06001, 18'h36002};
    chk_seq("t6_seq", base, e);
    chk("t6_done_cnt", 32'(done_n - d0), 32'd1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
